sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/cpu_defs.sv | 15 +
 rtl/sram_arbiter.sv | 95 +++++++++
 tb/tb_sram_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: outstanding-owner encoding and requester port ids.
package cpu_defs;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } owner_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle SRAM; one grant per cycle,
// response returned to the owning port exactly one cycle after acceptance.
module sram_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  port_t  last_grant_p0;
  owner_t owner_p1;
  logic   gnt_inst_p0;
  logic   gnt_data_p0;

  // Stage p0: combinational grant; data wins a tie unless it won the previous grant.
  always_comb begin
    gnt_data_p0 = !rst && data_req && (!inst_req || (last_grant_p0 == PORT_INST));
    gnt_inst_p0 = !rst && inst_req && !gnt_data_p0;
  end

  always_comb begin
    inst_addr_ok = gnt_inst_p0;
    data_addr_ok = gnt_data_p0;
    sram_en      = 1'b0;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (gnt_inst_p0) begin
      sram_en    = 1'b1;
      sram_we    = inst_wr ? inst_wstrb : {STRB_W{1'b0}};
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (gnt_data_p0) begin
      sram_en    = 1'b1;
      sram_we    = data_wr ? data_wstrb : {STRB_W{1'b0}};
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_p0 <= PORT_INST;
      owner_p1      <= OWN_NONE;
    end else begin
      if (gnt_inst_p0) begin
        last_grant_p0 <= PORT_INST;
      end else if (gnt_data_p0) begin
        last_grant_p0 <= PORT_DATA;
      end
      if (gnt_inst_p0) begin
        owner_p1 <= OWN_INST;
      end else if (gnt_data_p0) begin
        owner_p1 <= OWN_DATA;
      end else begin
        owner_p1 <= OWN_NONE;
      end
    end
  end

  // Stage p1: response to the registered owner; a response in flight when rst rises is dropped.
  always_comb begin
    inst_data_ok = !rst && (owner_p1 == OWN_INST);
    data_data_ok = !rst && (owner_p1 == OWN_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : {DATA_W{1'b0}};
    data_rdata   = data_data_ok ? sram_rdata : {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed cycle table followed by randomized traffic against a queue model.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OUT_W = 5 + SW + AW + 3 * DW;

  localparam logic [31:0] IA  = 32'h0000_0020;
  localparam logic [31:0] DA  = 32'h0000_0100;
  localparam logic [31:0] IWD = 32'h1234_5678;
  localparam logic [31:0] DWD = 32'hCAFE_F00D;
  localparam logic [3:0]  IST = 4'b0011;
  localparam logic [3:0]  DST = 4'b1100;

  localparam int P_NONE = 0;
  localparam int P_INST = 1;
  localparam int P_DATA = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [SW-1:0] inst_wstrb, data_wstrb;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          sram_en;
  logic [SW-1:0] sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  typedef struct {
    logic             rst, ir, iw, dr, dw;
    logic [31:0]      srd;
    logic [OUT_W-1:0] exp;
  } vec_t;

  typedef struct {
    int port;
    int due;
  } resp_t;

  vec_t  tbl[$];
  resp_t rq[$];

  function automatic logic [OUT_W-1:0] pk(input logic iao, input logic dao, input logic ido,
                                          input logic ddo, input logic en, input logic [3:0] we,
                                          input logic [31:0] addr, input logic [31:0] wd,
                                          input logic [31:0] ird, input logic [31:0] drd);
    return {iao, dao, ido, ddo, en, we, addr, wd, ird, drd};
  endfunction

  function automatic logic [OUT_W-1:0] actual();
    return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we,
            sram_addr, sram_wdata, inst_rdata, data_rdata};
  endfunction

  task automatic add(input logic r, input logic ir, input logic iw, input logic dr,
                     input logic dw, input logic [31:0] srd, input logic [OUT_W-1:0] exp);
    vec_t v;
    v.rst = r; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.srd = srd; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; inst_wr = 1'b0; data_wr = 1'b0;
    inst_addr = IA; data_addr = DA; inst_wdata = IWD; data_wdata = DWD;
    inst_wstrb = IST; data_wstrb = DST; sram_rdata = '0;

    // reset, tie alternation, single read, write, back-to-back, reset mid-op, first tie after reset
    add(1, 1, 0, 1, 0, 32'h0,        pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, 0, 32'h0,        pk(0, 1, 0, 0, 1, 0, DA, DWD, 0, 0));
    add(0, 1, 0, 1, 0, 32'h1111_1111, pk(1, 0, 0, 1, 1, 0, IA, IWD, 0, 32'h1111_1111));
    add(0, 1, 0, 1, 0, 32'h2222_2222, pk(0, 1, 1, 0, 1, 0, DA, DWD, 32'h2222_2222, 0));
    add(0, 1, 0, 1, 0, 32'h3333_3333, pk(1, 0, 0, 1, 1, 0, IA, IWD, 0, 32'h3333_3333));
    add(0, 0, 0, 0, 0, 32'h4444_4444, pk(0, 0, 1, 0, 0, 0, 0, 0, 32'h4444_4444, 0));
    add(0, 0, 0, 1, 0, 32'h0,        pk(0, 1, 0, 0, 1, 0, DA, DWD, 0, 0));
    add(0, 0, 0, 0, 0, 32'hDEAD_BEEF, pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF));
    add(0, 1, 1, 0, 0, 32'h0,        pk(1, 0, 0, 0, 1, IST, IA, IWD, 0, 0));
    add(0, 0, 0, 0, 0, 32'h5555_5555, pk(0, 0, 1, 0, 0, 0, 0, 0, 32'h5555_5555, 0));
    add(0, 0, 0, 1, 0, 32'h0,        pk(0, 1, 0, 0, 1, 0, DA, DWD, 0, 0));
    add(0, 1, 0, 0, 0, 32'hA5A5_A5A5, pk(1, 0, 0, 1, 1, 0, IA, IWD, 0, 32'hA5A5_A5A5));
    add(0, 0, 0, 0, 0, 32'h5A5A_5A5A, pk(0, 0, 1, 0, 0, 0, 0, 0, 32'h5A5A_5A5A, 0));
    add(0, 0, 0, 1, 1, 32'h0,        pk(0, 1, 0, 0, 1, DST, DA, DWD, 0, 0));
    add(1, 0, 0, 1, 0, 32'h7777_7777, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 32'h6666_6666, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, 0, 32'h0,        pk(0, 1, 0, 0, 1, 0, DA, DWD, 0, 0));
    add(0, 0, 0, 0, 0, 32'h8888_8888, pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h8888_8888));

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; inst_req = tbl[i].ir; inst_wr = tbl[i].iw;
      data_req = tbl[i].dr; data_wr = tbl[i].dw; sram_rdata = tbl[i].srd;
      #1;
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    begin
      logic        ip, dp, iw_r, dw_r, r;
      logic [31:0] ia_r, da_r, iwd_r, dwd_r, srd;
      logic [3:0]  ist_r, dst_r;
      int          last, win;
      logic        e_ido, e_ddo;
      logic [3:0]  e_we;
      logic [31:0] e_addr, e_wd;
      ip = 0; dp = 0; iw_r = 0; dw_r = 0;
      ia_r = 0; da_r = 0; iwd_r = 0; dwd_r = 0; ist_r = 0; dst_r = 0;
      last = P_INST;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        r = (c == 0) || ($urandom_range(0, 63) == 0);
        if (!ip && $urandom_range(0, 3) != 0) begin
          ip = 1; iw_r = 1'($urandom); ia_r = $urandom; iwd_r = $urandom; ist_r = 4'($urandom);
        end
        if (!dp && $urandom_range(0, 3) != 0) begin
          dp = 1; dw_r = 1'($urandom); da_r = $urandom; dwd_r = $urandom; dst_r = 4'($urandom);
        end
        srd = $urandom;
        rst = r; inst_req = ip; inst_wr = iw_r; inst_addr = ia_r; inst_wdata = iwd_r;
        inst_wstrb = ist_r; data_req = dp; data_wr = dw_r; data_addr = da_r;
        data_wdata = dwd_r; data_wstrb = dst_r; sram_rdata = srd;

        if (r) win = P_NONE;
        else if (ip && dp) win = (last == P_INST) ? P_DATA : P_INST;
        else if (ip) win = P_INST;
        else if (dp) win = P_DATA;
        else win = P_NONE;

        e_ido = !r && rq.size() > 0 && rq[0].due == c && rq[0].port == P_INST;
        e_ddo = !r && rq.size() > 0 && rq[0].due == c && rq[0].port == P_DATA;
        e_we = 0; e_addr = 0; e_wd = 0;
        if (win == P_INST) begin
          e_we = iw_r ? ist_r : 4'b0; e_addr = ia_r; e_wd = iwd_r;
        end else if (win == P_DATA) begin
          e_we = dw_r ? dst_r : 4'b0; e_addr = da_r; e_wd = dwd_r;
        end
        #1;
        check($sformatf("random[%0d]", c),
              pk(win == P_INST, win == P_DATA, e_ido, e_ddo, win != P_NONE, e_we, e_addr, e_wd,
                 e_ido ? srd : 32'h0, e_ddo ? srd : 32'h0));

        if (r) begin
          rq.delete();
          last = P_INST;
        end else begin
          while (rq.size() > 0 && rq[0].due <= c) void'(rq.pop_front());
          if (win != P_NONE) begin
            rq.push_back('{port: win, due: c + 1});
            last = win;
            if (win == P_INST) ip = 0;
            else dp = 0;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
